// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU control sequencer: FSM state encoding, opcode constants, opcode one-hot helper.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_A    = 3'd1,
    S_OP   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [2:0] OP_SHL = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  // Bit 7 is shl (opcode 0), bit 0 is not (opcode 7).
  function automatic logic [7:0] op_onehot(input logic [2:0] op);
    return 8'h80 >> op;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_dec.sv
// Combinational opcode decoder: 3-bit opcode to 8-bit one-hot ALU select, forced to zero when en is low.
module alu_op_dec
  import alu_seq_pkg::*;
(
  input  logic       en,
  input  logic [2:0] opcode,
  output logic [7:0] onehot
);

  assign onehot = en ? op_onehot(opcode) : 8'h00;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Moore micro-sequencer running one register-to-register ALU instruction over the shared bus.
// Optional ALU_SEQ_FLAGS_EN adds zero/negative flags captured from the bus at the end of the write step.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter  int NREG = 4,
  parameter  int DW   = 16,
  localparam int SW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      opcode,
  input  logic [SW-1:0]   rs,
  input  logic [SW-1:0]   rt,
  input  logic [SW-1:0]   rd,
  input  logic [DW-1:0]   data,
  output logic            busy,
  output logic            done,
  output logic [NREG-1:0] reg_oe,
  output logic [NREG-1:0] reg_ld,
  output logic            la,
  output logic            ialu,
  output logic            ealu,
  output logic [7:0]      alu_op
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic            flag_z,
  output logic            flag_n
`endif
);

  state_t          state, state_nxt;
  logic [2:0]      op_q;
  logic [SW-1:0]   rs_q, rt_q, rd_q;
  logic            accept;
  logic [2:0]      op_n;
  logic [SW-1:0]   rs_n, rt_n, rd_n;

  logic            busy_n, done_n, la_n, ialu_n, ealu_n, op_en;
  logic [NREG-1:0] oe_n, ld_n;
  logic [7:0]      alu_op_n;

  assign accept = (state == IDLE) && start;

  // Outputs are registered, so they are decoded from the state being entered and
  // from the fields that will be latched, letting the latch edge drive S_A at once.
  assign op_n = accept ? opcode : op_q;
  assign rs_n = accept ? rs     : rs_q;
  assign rt_n = accept ? rt     : rt_q;
  assign rd_n = accept ? rd     : rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      reg_oe <= '0;
      reg_ld <= '0;
      la     <= 1'b0;
      ialu   <= 1'b0;
      ealu   <= 1'b0;
      alu_op <= '0;
    end else begin
      state  <= state_nxt;
      op_q   <= op_n;
      rs_q   <= rs_n;
      rt_q   <= rt_n;
      rd_q   <= rd_n;
      busy   <= busy_n;
      done   <= done_n;
      reg_oe <= oe_n;
      reg_ld <= ld_n;
      la     <= la_n;
      ialu   <= ialu_n;
      ealu   <= ealu_n;
      alu_op <= alu_op_n;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = S_A;
      S_A:     state_nxt = S_OP;
      S_OP:    state_nxt = S_WR;
      S_WR:    state_nxt = S_DONE;
      S_DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_n = 1'b0;
    done_n = 1'b0;
    la_n   = 1'b0;
    ialu_n = 1'b0;
    ealu_n = 1'b0;
    oe_n   = '0;
    ld_n   = '0;
    case (state_nxt)
      S_A: begin
        busy_n     = 1'b1;
        la_n       = 1'b1;
        oe_n[rs_n] = 1'b1;
      end
      S_OP: begin
        busy_n = 1'b1;
        ialu_n = 1'b1;
        // not is unary: leave the bus undriven instead of sourcing rt
        if (op_n != OP_NOT) oe_n[rt_n] = 1'b1;
      end
      S_WR: begin
        busy_n     = 1'b1;
        ealu_n     = 1'b1;
        ld_n[rd_n] = 1'b1;
      end
      S_DONE:  done_n = 1'b1;
      default: ;
    endcase
  end

  assign op_en = (state_nxt == S_OP) || (state_nxt == S_WR);

  alu_op_dec u_dec (
    .en     (op_en),
    .opcode (op_n),
    .onehot (alu_op_n)
  );

`ifdef ALU_SEQ_FLAGS_EN
  // The bus carries the ALU result during S_WR; sample it on the way out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (state == S_WR) begin
      flag_z <= (data == '0);
      flag_n <= data[DW-1];
    end
  end
`else
  logic unused_data;
  assign unused_data = ^data;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: stimulus queues expected per-cycle control vectors, a monitor compares them.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  opcode = '0;
  logic [1:0]  rs = '0, rt = '0, rd = '0;
  logic [15:0] data = '0;
  logic        busy, done, la, ialu, ealu;
  logic [3:0]  reg_oe, reg_ld;
  logic [7:0]  alu_op;
`ifdef ALU_SEQ_FLAGS_EN
  logic        flag_z, flag_n;
`endif

  alu_seq_ctrl #(.NREG(4), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .data(data),
    .busy(busy), .done(done), .reg_oe(reg_oe), .reg_ld(reg_ld),
    .la(la), .ialu(ialu), .ealu(ealu), .alu_op(alu_op)
`ifdef ALU_SEQ_FLAGS_EN
    , .flag_z(flag_z), .flag_n(flag_n)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] oe;
    logic [3:0] ld;
    logic       la;
    logic       ialu;
    logic       ealu;
    logic [7:0] op;
    logic       fz;
    logic       fn;
  } vec_t;

  vec_t sb[$];
  int   done_cyc[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  logic [1:0] idle_flags = '0;
  logic cur_z = 1'b0, cur_n = 1'b0;

  function automatic vec_t sample();
    vec_t v;
    v = '0;
    v.busy = busy; v.done = done; v.oe = reg_oe; v.ld = reg_ld;
    v.la = la; v.ialu = ialu; v.ealu = ealu; v.op = alu_op;
`ifdef ALU_SEQ_FLAGS_EN
    v.fz = flag_z; v.fn = flag_n;
`endif
    return v;
  endfunction

  task automatic check_vec(input string name, input vec_t act, input vec_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  // Expected behaviour: four steps per instruction, each a whole control vector.
  task automatic push_instr(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                            input logic [1:0] d, input logic [15:0] bus);
    vec_t v;
    logic [7:0] sel;
    sel = 8'd1 << (7 - int'(op));
    data = bus;
    v = '0; v.busy = 1; v.la = 1; v.oe = 4'b0001 << a; v.fz = cur_z; v.fn = cur_n;
    sb.push_back(v);
    v = '0; v.busy = 1; v.ialu = 1; v.op = sel; v.fz = cur_z; v.fn = cur_n;
    v.oe = (op == 3'd7) ? 4'b0000 : (4'b0001 << b);
    sb.push_back(v);
    v = '0; v.busy = 1; v.ealu = 1; v.ld = 4'b0001 << d; v.op = sel; v.fz = cur_z; v.fn = cur_n;
    sb.push_back(v);
`ifdef ALU_SEQ_FLAGS_EN
    cur_z = (bus == 16'h0000);
    cur_n = bus[15];
`endif
    v = '0; v.done = 1; v.fz = cur_z; v.fn = cur_n;
    sb.push_back(v);
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] d, input logic [15:0] bus);
    int n = 0;
    @(negedge clk);
    while (busy || done) begin
      if (n++ > 20) begin
        compared++; mismatched++;
        $display("FAIL idle_wait: busy=%b done=%b required idle within 20 cycles", busy, done);
        return;
      end
      @(negedge clk);
    end
    opcode = op; rs = a; rt = b; rd = d; start = 1'b1;
    push_instr(op, a, b, d, bus);
    // start and fields are garbage for the rest of the instruction and must be ignored
    repeat (4) begin
      @(negedge clk);
      start = 1'($urandom); opcode = 3'($urandom);
      rs = 2'($urandom); rt = 2'($urandom); rd = 2'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin : monitor
    vec_t a, e;
    logic excl;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        idle_flags = '0;
      end else begin
        a = sample();
        excl = ($countones(a.oe) <= 1) && !((|a.oe) && a.ealu);
        compared++;
        if (!excl) begin
          mismatched++;
          $display("FAIL bus_excl @cyc %0d: reg_oe=%b ealu=%b required one driver at most", cyc, a.oe, a.ealu);
        end
        if (a.busy || a.done) begin
          if (sb.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected @cyc %0d: got %h required idle", cyc, a);
          end else begin
            e = sb.pop_front();
            check_vec("step", a, e);
            if (e.done) idle_flags = {e.fz, e.fn};
            if (a.done) done_cyc.push_back(cyc);
          end
        end else begin
          e = '0; e.fz = idle_flags[1]; e.fn = idle_flags[0];
          check_vec("idle", a, e);
        end
      end
    end
  end

  initial begin : stim
    #2;
    check_vec("reset", sample(), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(3'd1, 2'd2, 2'd3, 2'd1, 16'h1234);   // add r1=r2+r3
    issue(3'd7, 2'd2, 2'd0, 2'd0, 16'h0000);   // not r0=~r2, zero result
    issue(3'd2, 2'd1, 2'd1, 2'd1, 16'h8001);   // sub, negative result, rd==rs==rt
    repeat (4) @(negedge clk);                 // flags must hold through idle

    // start held high for 10 cycles: exactly two acceptances, 5 cycles apart
    @(negedge clk);
    done_cyc.delete();
    opcode = 3'd4; rs = 2'd1; rt = 2'd0; rd = 2'd3; start = 1'b1;
    push_instr(3'd4, 2'd1, 2'd0, 2'd3, 16'h00f0);
    push_instr(3'd4, 2'd1, 2'd0, 2'd3, 16'h00f0);
    repeat (10) @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    compared++;
    if (done_cyc.size() != 2) begin
      mismatched++;
      $display("FAIL done_count: got %0d required 2", done_cyc.size());
    end else begin
      compared++;
      if (done_cyc[1] - done_cyc[0] != 5) begin
        mismatched++;
        $display("FAIL done_spacing: got %0d required 5", done_cyc[1] - done_cyc[0]);
      end
    end

    // async reset while in S_OP: everything drops at once and no write happens
    @(negedge clk);
    opcode = 3'd5; rs = 2'd0; rt = 2'd1; rd = 2'd2; start = 1'b1;
    push_instr(3'd5, 2'd0, 2'd1, 2'd2, 16'h0000);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_vec("async_reset", sample(), '0);
    sb.delete();
    cur_z = 1'b0; cur_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int op = 0; op < 8; op++)
      issue(3'(op), 2'($urandom), 2'($urandom), 2'($urandom), 16'($urandom));
    for (int k = 0; k < 12; k++)
      issue(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
            ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));

    repeat (6) @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending steps required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
